// File: rtl/mux_rr_reg.sv
// mux_rr_reg: N_CH-to-1 round-robin mux feeding one registered valid/ready output stage.
// Latency: an input accepted in cycle T is presented on o_out_* in cycle T+1. Throughput is one transfer per cycle.
// Backpressure: while the output is full and i_out_ready=0, o_in_ready is all zero and the outputs hold.
//
// Ports:
//   clk, rst_n         rising-edge clock, asynchronous active-low reset
//   i_in_valid         per-channel request
//   i_in_data          channel i data at [i*DATA_W +: DATA_W]
//   o_in_ready         one-hot (or zero) combinational grant; independent of i_in_data
//   o_out_valid        output register holds data
//   o_out_data         registered data
//   o_out_ch           index of the channel that supplied o_out_data
//   i_out_ready        consumer accepts o_out_data
//   i_force_en         (MUX_RR_FORCE_SEL_EN only) bypass arbitration
//   i_force_sel        (MUX_RR_FORCE_SEL_EN only) channel to grant while forced
//
// Optional feature macro: MUX_RR_FORCE_SEL_EN. When defined, it adds the forced-select ports.
// A forced grant does not move the round-robin pointer.
module mux_rr_reg #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int CH_W   = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          i_in_valid,
    input  logic [N_CH*DATA_W-1:0]   i_in_data,
    output logic [N_CH-1:0]          o_in_ready,
    output logic                     o_out_valid,
    output logic [DATA_W-1:0]        o_out_data,
    output logic [CH_W-1:0]          o_out_ch,
    input  logic                     i_out_ready
`ifdef MUX_RR_FORCE_SEL_EN
    ,
    input  logic                     i_force_en,
    input  logic [CH_W-1:0]          i_force_sel
`endif
);

    localparam logic [CH_W-1:0] PTR_RST = CH_W'(N_CH - 1);

    logic [CH_W-1:0]   r_ptr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_ch;

    logic              w_can_load;
    logic              w_rr_vld;
    logic [CH_W-1:0]   w_rr_grant;
    logic              w_grant_vld;
    logic [CH_W-1:0]   w_grant;
    logic              w_forced;
    logic [N_CH-1:0]   w_ready;
    logic [DATA_W-1:0] w_sel_data;

    // The output register can accept new data when it is empty or is being popped this cycle.
    assign w_can_load = !r_out_valid || i_out_ready;

    // Round-robin search starting at ptr+1. The loop runs from the farthest offset to the nearest offset,
    // so the last match written is the first requester after ptr.
    always_comb begin
        w_rr_vld   = 1'b0;
        w_rr_grant = '0;
        for (int k = N_CH; k >= 1; k--) begin
            if (i_in_valid[(int'(r_ptr) + k) % N_CH]) begin
                w_rr_vld   = 1'b1;
                w_rr_grant = CH_W'((int'(r_ptr) + k) % N_CH);
            end
        end
    end

`ifdef MUX_RR_FORCE_SEL_EN
    always_comb begin
        w_forced    = 1'b0;
        w_grant_vld = w_rr_vld;
        w_grant     = w_rr_grant;
        if (i_force_en) begin
            w_forced    = 1'b1;
            w_grant     = i_force_sel;
            // An out-of-range select gives no grant.
            w_grant_vld = (int'(i_force_sel) < N_CH) && i_in_valid[i_force_sel];
        end
    end
`else
    always_comb begin
        w_forced    = 1'b0;
        w_grant_vld = w_rr_vld;
        w_grant     = w_rr_grant;
    end
`endif

    // Ready is forced low during reset. Otherwise ready is valid only when the output stage can load.
    always_comb begin
        w_ready = '0;
        if (rst_n && w_can_load && w_grant_vld) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign w_sel_data = i_in_data[int'(w_grant) * DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= PTR_RST;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_can_load) begin
            if (w_grant_vld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_ch    <= w_grant;
                if (!w_forced) begin
                    r_ptr <= w_grant;
                end
            end else begin
                // Drain: data and channel index keep their last values.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_in_ready  = w_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_ch    = r_out_ch;

endmodule
